subleq_control: RTL

Sequencer for the URISC SUBLEQ core. It drives the 16-bit single-port Memory block, which has combinational read and synchronous write, through its address, data, write-enable and read-enable interface. For each instruction it fetches the three operand words A, B and C, reads mem[A] and mem[B], and writes mem[B] − mem[A] back to mem[B]. It then branches to C if the result is ≤ 0 (signed); otherwise it continues at PC+3. It sits between the top level (start/halt/status) and Memory, and contains the PC and the internal MAR/MDR equivalents.

---
 rtl/subleq_pkg.sv | 19 +
 rtl/subleq_alu.sv | 14 +
 rtl/subleq_control.sv | 138 +++++++++++++
 3 files changed

// File: rtl/subleq_pkg.sv
// Shared types and constants for the SUBLEQ sequencer.
package subleq_pkg;

    localparam int          DATA_W_DEF    = 16;
    localparam logic [15:0] HALT_ADDR_DEF = 16'hFFFF;
    localparam int          INSTR_LEN     = 3;

    typedef enum logic [2:0] {
        IDLE,
        FETCH_A,
        FETCH_B,
        FETCH_C,
        READ_A,
        READ_B,
        WRITE,
        HALT
    } state_t;

endpackage

// File: rtl/subleq_alu.sv
// Subtract-and-test unit: diff = b - a (wrapping), leq when diff is <= 0 as a signed value.
module subleq_alu #(
    parameter int DATA_W = 16
) (
    input  logic [DATA_W-1:0] b,
    input  logic [DATA_W-1:0] a,
    output logic [DATA_W-1:0] diff,
    output logic              leq
);

    assign diff = b - a;
    assign leq  = diff[DATA_W-1] | (diff == '0);

endmodule

// File: rtl/subleq_control.sv
// SUBLEQ instruction sequencer: fetches A/B/C, computes mem[B]-mem[A], writes it back and branches.
module subleq_control
    import subleq_pkg::*;
#(
    parameter int                DATA_W    = DATA_W_DEF,
    parameter logic [DATA_W-1:0] RESET_PC  = '0,
    parameter logic [DATA_W-1:0] HALT_ADDR = DATA_W'(HALT_ADDR_DEF)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    output logic [DATA_W-1:0] pc,
    output logic              busy,
    output logic              halted
);

    state_t state_reg, state_next;
    logic [DATA_W-1:0] pc_reg, pc_next;
    logic [DATA_W-1:0] a_reg, a_next;
    logic [DATA_W-1:0] b_reg, b_next;
    logic [DATA_W-1:0] c_reg, c_next;
    logic [DATA_W-1:0] opa_reg, opa_next;
    logic [DATA_W-1:0] res_reg, res_next;

    logic [DATA_W-1:0] alu_b, alu_a, alu_diff;
    logic              alu_leq;

    subleq_alu #(.DATA_W(DATA_W)) u_alu (
        .b    (alu_b),
        .a    (alu_a),
        .diff (alu_diff),
        .leq  (alu_leq)
    );

    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        a_next     = a_reg;
        b_next     = b_reg;
        c_next     = c_reg;
        opa_next   = opa_reg;
        res_next   = res_reg;
        mem_addr   = '0;
        mem_wdata  = '0;
        mem_we     = 1'b0;
        mem_re     = 1'b0;
        // Outside READ_B the ALU sees res - 0, which gives the branch test in WRITE.
        alu_b      = res_reg;
        alu_a      = '0;

        case (state_reg)
            IDLE, HALT: begin
                if (start) begin
                    state_next = FETCH_A;
                    pc_next    = RESET_PC;
                end
            end
            FETCH_A: begin
                mem_addr   = pc_reg;
                mem_re     = 1'b1;
                a_next     = mem_rdata;
                state_next = FETCH_B;
            end
            FETCH_B: begin
                mem_addr   = pc_reg + DATA_W'(1);
                mem_re     = 1'b1;
                b_next     = mem_rdata;
                state_next = FETCH_C;
            end
            FETCH_C: begin
                mem_addr   = pc_reg + DATA_W'(2);
                mem_re     = 1'b1;
                c_next     = mem_rdata;
                state_next = READ_A;
            end
            READ_A: begin
                mem_addr   = a_reg;
                mem_re     = 1'b1;
                opa_next   = mem_rdata;
                state_next = READ_B;
            end
            READ_B: begin
                mem_addr   = b_reg;
                mem_re     = 1'b1;
                alu_b      = mem_rdata;
                alu_a      = opa_reg;
                res_next   = alu_diff;
                state_next = WRITE;
            end
            WRITE: begin
                mem_addr  = b_reg;
                mem_wdata = res_reg;
                mem_we    = 1'b1;
                if (alu_leq && (c_reg == HALT_ADDR)) begin
                    pc_next    = HALT_ADDR;
                    state_next = HALT;
                end else if (alu_leq) begin
                    pc_next    = c_reg;
                    state_next = FETCH_A;
                end else begin
                    pc_next    = pc_reg + DATA_W'(INSTR_LEN);
                    state_next = FETCH_A;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            pc_reg    <= RESET_PC;
            a_reg     <= '0;
            b_reg     <= '0;
            c_reg     <= '0;
            opa_reg   <= '0;
            res_reg   <= '0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            a_reg     <= a_next;
            b_reg     <= b_next;
            c_reg     <= c_next;
            opa_reg   <= opa_next;
            res_reg   <= res_next;
        end
    end

    assign pc     = pc_reg;
    assign busy   = (state_reg != IDLE) && (state_reg != HALT);
    assign halted = (state_reg == HALT);

endmodule
